// File: rtl/systolic_feed_ctrl.sv
// Sequencer for one BLOCK_SIZE x BLOCK_SIZE systolic matrix-multiply pass: clear, skewed operand feed, drain, result handshake.
// Optional pass/stall performance counters are enabled by defining SYSTOLIC_PERF_CNT_EN.
module systolic_feed_ctrl #(
  parameter int BLOCK_SIZE = 3,
  localparam int CNT_WIDTH = $clog2(2 * BLOCK_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  pe_clear,
  output logic [BLOCK_SIZE-1:0] load_a,
  output logic [BLOCK_SIZE-1:0] load_b,
  output logic [BLOCK_SIZE-1:0] lane_valid,
  output logic                  result_valid,
`ifdef SYSTOLIC_PERF_CNT_EN
  output logic [15:0]           perf_passes,
  output logic [15:0]           perf_stall,
`endif
  input  logic                  result_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] FEED_LAST  = CNT_WIDTH'(2 * BLOCK_SIZE - 2);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'((BLOCK_SIZE > 1) ? BLOCK_SIZE - 2 : 0);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  int                    cnt_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt restarts from zero on every state entry and only advances in FEED/DRAIN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        state_nxt = S_FEED;
      end
      S_FEED: begin
        if (cnt == FEED_LAST) begin
          state_nxt = (BLOCK_SIZE == 1) ? S_DONE : S_DRAIN;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        if (result_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cnt_int = int'(cnt);

  // Lane i is strobed at cnt==i and stays valid for BLOCK_SIZE cycles, giving the diagonal skew.
  always_comb begin
    in_ready     = (state == S_IDLE);
    busy         = (state != S_IDLE);
    pe_clear     = (state == S_CLEAR);
    result_valid = (state == S_DONE);
    load_a       = '0;
    lane_valid   = '0;
    if (state == S_FEED) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        load_a[i]     = (cnt_int == i);
        lane_valid[i] = (cnt_int >= i) && (cnt_int <= i + BLOCK_SIZE - 1);
      end
    end
  end

  assign load_b = load_a;

`ifdef SYSTOLIC_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_passes <= '0;
      perf_stall  <= '0;
    end else if (state == S_DONE) begin
      if (result_ack) perf_passes <= sat_inc(perf_passes);
      else            perf_stall  <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
- Sequencer for one BLOCK_SIZE x BLOCK_SIZE systolic matrix-multiply pass.
- Drives the per-lane load strobes of the A-row and B-column operand shift registers with the diagonal skew the array needs, clears the PE accumulators, and waits for the array to drain.
- Presents a result-valid/acknowledge handshake to the result collector.
- Sits between the top-level command interface and the operand shift-register banks / PE grid.

Parameters:
- BLOCK_SIZE, 3, matrix dimension N; lanes per operand side; legal range 1..16.
- CNT_WIDTH, $clog2(2*BLOCK_SIZE), width of the internal phase counter; derived, never overridden.

Ports:
- clk  input  1  system clock; all controller state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply pass; accepted only when in_ready=1.
- in_ready  output  1  controller idle and able to accept start.
- busy  output  1  pass in progress (CLEAR, FEED, DRAIN or DONE).
- pe_clear  output  1  zero all PE accumulators and pipeline registers.
- load_a  output  BLOCK_SIZE  bit i = load strobe for A-row shift register i.
- load_b  output  BLOCK_SIZE  bit j = load strobe for B-column shift register j; identical timing to load_a.
- lane_valid  output  BLOCK_SIZE  bit i = lane i currently presenting a valid operand.
- result_valid  output  1  all PE results final; held until acknowledged.
- result_ack  input  1  collector has taken results.

Behaviour:
- All outputs are decoded from registered state and counter only; no input-to-output combinational path.
  - Outputs are stable well before the shift registers' falling-edge capture.
- States:
  - IDLE: in_ready=1, all other outputs 0.
    - start=1 -> CLEAR.
  - CLEAR: exactly 1 cycle; pe_clear=1.
    - -> FEED with cnt=0.
  - FEED: lasts 2N-1 cycles, cnt = 0..2N-2.
    - load_a[i] = load_b[i] = (cnt==i), for i<N.
    - lane_valid[i] = (cnt>=i) && (cnt<=i+N-1).
    - At cnt==2N-2 -> DRAIN with cnt=0, or -> DONE if N==1.
  - DRAIN: lasts N-1 cycles, cnt = 0..N-2; all strobes 0.
    - The last product reaches PE(N-1,N-1) and is accumulated.
    - At cnt==N-2 -> DONE.
  - DONE: result_valid=1 until result_ack=1 is sampled.
    - On ack -> IDLE.
- busy=1 in every state except IDLE.
- Latency: start sampled on edge k gives:
  - pe_clear during cycle k+1;
  - load strobes from k+2;
  - result_valid first high in cycle k+3N, assuming no back-pressure.
  - For N=3: result_valid at k+9.
- start while not in IDLE is ignored; it is neither queued nor an error.
- start and result_ack both high in DONE: the ack is honoured and start is ignored. The next start is accepted from IDLE one cycle later.
- result_ack outside DONE is ignored.
- cnt resets to 0 on every state entry. It never wraps within a pass, because its width covers 2N-2.
- Reset (any state, including mid-FEED or DONE):
  - next state IDLE, cnt=0;
  - after the reset edge, in_ready=1 and every other output 0.
  - Any partial pass is abandoned; the operand shift registers and PEs are reset by their own reset.

Optional Feature:
- Macro: SYSTOLIC_PERF_CNT_EN.
- Defined:
  - adds output port perf_passes [15:0]: count of completed passes, incremented on each DONE->IDLE transition, saturating at 16'hFFFF, cleared by reset;
  - adds output port perf_stall [15:0]: count of cycles spent in DONE with result_ack=0, also saturating and reset-cleared.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- N=3, reset then single start pulse at cycle 0 with result_ack tied high:
  - pe_clear high cycle 1;
  - load_a = 001/010/100 in cycles 2/3/4, 000 in 5-8;
  - lane_valid 001,011,111,110,100 in cycles 2-6;
  - result_valid high cycle 9 only;
  - in_ready high again cycle 10.
- Back-pressure: result_ack low for 5 cycles after result_valid rises:
  - result_valid and busy held for all 5 cycles;
  - ack in cycle 14 -> IDLE in cycle 15;
  - perf_stall=5 when SYSTOLIC_PERF_CNT_EN is defined.
- start held continuously high for 30 cycles with ack tied high:
  - back-to-back passes, CLEAR at cycles 1, 11, 21;
  - no start accepted while busy.
- reset asserted during FEED (cnt=2):
  - next cycle all strobes 0, in_ready=1, busy=0;
  - a subsequent start gives normal timing from its acceptance.
- N=1 instance, start at cycle 0:
  - pe_clear cycle 1; load_a=1 and lane_valid=1 in cycle 2;
  - no DRAIN; result_valid in cycle 3.
- SYSTOLIC_PERF_CNT_EN defined, 3 passes, then reset:
  - perf_passes reads 3 before reset and 0 after.
